// File: rtl/div_seq_unit.sv
// div_seq_unit: multicycle signed restoring divider, one quotient bit per clock.
// A zero divisor finishes in a single cycle and raises data_exception.
// Optional build macro: DIV_REMAINDER_EN adds the data_remainder output.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for ctrl_div; operands sampled on the start edge
// S_RUN  | one shift/subtract step per cycle, WIDTH steps in total
// S_DONE | result valid, data_resultRDY high for this single cycle

module div_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef DIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo, quo_nxt;
    logic [WIDTH:0]   rem, rem_nxt;
    logic [WIDTH:0]   div_abs;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH:0]   b_ext, b_abs;
    logic             sign_q;
    logic             div_zero;
    logic             start;
`ifdef DIV_REMAINDER_EN
    logic             a_neg;
`endif

    // Operand magnitudes; |A| fits WIDTH bits unsigned, |B| is kept WIDTH+1 wide.
    always_comb begin
        a_abs    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_ext    = {data_operandB[WIDTH-1], data_operandB};
        b_abs    = b_ext[WIDTH] ? -b_ext : b_ext;
        div_zero = (data_operandB == '0);
        start    = (state == S_IDLE) && ctrl_div;
    end

    // One restoring step: shift the dividend MSB into rem, subtract if it fits.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        if (rem_sh >= {1'b0, div_abs}) begin
            rem_nxt = rem_sh[WIDTH:0] - div_abs;
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[WIDTH:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt      = state;
        data_resultRDY = 1'b0;
        busy           = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl_div) begin
                    state_nxt = div_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy           = 1'b1;
                data_resultRDY = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result write on the final step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            quo            <= '0;
            rem            <= '0;
            div_abs        <= '0;
            sign_q         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
            a_neg          <= 1'b0;
            data_remainder <= '0;
`endif
        end else if (start) begin
            cnt            <= '0;
            quo            <= a_abs;
            rem            <= '0;
            div_abs        <= b_abs;
            sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            data_exception <= div_zero;
`ifdef DIV_REMAINDER_EN
            a_neg          <= data_operandA[WIDTH-1];
`endif
            if (div_zero) begin
                data_result <= '0;
`ifdef DIV_REMAINDER_EN
                data_remainder <= data_operandA;
`endif
            end
        end else if (state == S_RUN) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
                data_result <= sign_q ? -quo_nxt : quo_nxt;
`ifdef DIV_REMAINDER_EN
                data_remainder <= a_neg ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_div_seq_unit.sv
// tb_div_seq_unit: scoreboard bench for div_seq_unit with a plain-arithmetic
// reference model (signed / and % of the simulator on 64-bit integers).

module tb_div_seq_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         ctrl_div = 1'b0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;
`ifdef DIV_REMAINDER_EN
    logic [W-1:0] data_remainder;
`endif

    div_seq_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
`ifdef DIV_REMAINDER_EN
        ,
        .data_remainder (data_remainder)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         exc;
        int           due;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: truncating signed division on wide integers.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int t0);
        exp_t   e;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            e.res = '0;
            e.rem = a;
            e.exc = 1'b1;
            e.due = t0;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e.res = q[W-1:0];
            e.rem = r[W-1:0];
            e.exc = 1'b0;
            e.due = t0 + W;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clock) begin
        if (reset_n && data_resultRDY) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rdy actual=1 required=0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", data_result, e.res);
                chk("exception", {{(W-1){1'b0}}, data_exception}, {{(W-1){1'b0}}, e.exc});
                chk("latency_cycle", W'(cyc), W'(e.due));
`ifdef DIV_REMAINDER_EN
                chk("remainder", data_remainder, e.rem);
`endif
            end
        end
    end

    // Issue one operation as soon as the unit is idle; operands are scrambled afterwards.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_wait_timeout actual=busy required=idle (t=%0t)", $time);
            return;
        end
        ctrl_div = 1'b1;
        opa = a;
        opb = b;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
        sb_q.push_back(model(a, b, cyc));
        chk("busy_after_start", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, 1'b1});
        opa = $urandom;
        opb = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_result"}, data_result, '0);
        chk({tag, "_exception"}, {{(W-1){1'b0}}, data_exception}, '0);
        chk({tag, "_rdy"}, {{(W-1){1'b0}}, data_resultRDY}, '0);
        chk({tag, "_busy"}, {{(W-1){1'b0}}, busy}, '0);
`ifdef DIV_REMAINDER_EN
        chk({tag, "_remainder"}, data_remainder, '0);
`endif
    endtask

    initial begin
        logic [W-1:0] a, b;
        int n;

        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        do_op(32'd100, 32'd7);
        do_op(-32'sd100, 32'd7);
        do_op(32'd5, 32'd0);
        do_op(32'd9, 32'd3);
        do_op(32'h8000_0000, 32'hFFFF_FFFF);
        repeat (5) @(negedge clock);
        ctrl_div = 1'b1;
        opa = 32'd123;
        opb = 32'd4;
        @(negedge clock);
        ctrl_div = 1'b0;

        do_op(32'd1000, 32'd3);
        repeat (10) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midop_reset");
        sb_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        do_op(32'd8, 32'd2);
        do_op(32'd77, 32'd0);
        do_op(-32'sd77, -32'sd5);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = W'($signed($urandom_range(0, 16)) - 8); end
                2: begin a = $urandom; b = '0; end
                default: begin a = 32'h8000_0000; b = $urandom_range(0, 1) != 0 ? '1 : W'($urandom_range(1, 1000)); end
            endcase
            do_op(a, b);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
